// File: rtl/pwm_cfg_sched_if.sv
// pwm_cfg_sched_if: register-bus bundle between the system bus master and the PWM config scheduler.
interface pwm_cfg_sched_if;
  logic [7:0] addr;
  logic [31:0] wdata;
  logic wen;
  logic ren;
  logic [31:0] rdata;
  logic ack;
  modport master(output addr, wdata, wen, ren, input rdata, ack);
  modport slave(input addr, wdata, wen, ren, output rdata, ack);
endinterface

// File: rtl/pwm_cfg_sched.sv
// pwm_cfg_sched: per-channel bus/DSP config selection, committed immediately or on the PWM metacycle sync.
module pwm_cfg_sched #(
  parameter int CH = 4,
  parameter int CCW = 24
) (
  input  logic clk,
  input  logic rst,
  pwm_cfg_sched_if.slave sys,
  input  logic [CH*CCW-1:0] dsp_dat_i,
  input  logic [CH-1:0] dsp_vld_i,
  input  logic [CH-1:0] pwm_s_i,
  output logic [CH*CCW-1:0] cfg_o,
  output logic [CH-1:0] cfg_upd_o,
  output logic [CH-1:0] pend_o
);
  logic [CCW-1:0] shadow [CH];
  logic [CCW-1:0] stage [CH];
  logic [CH-1:0] src, sync, armed, req, chg, commit;
  logic [31:0] rd;
  logic apply_wr, ctrl_wr;
  assign apply_wr = sys.wen && sys.addr == 8'h24;
  assign ctrl_wr = sys.wen && sys.addr == 8'h20;
  assign pend_o = armed;
  // A sync request coincident with pwm_s commits on that same edge; a mode change drops any armed commit.
  always_comb begin
    req = '0;
    chg = '0;
    commit = '0;
    for (int n = 0; n < CH; n++) begin
      req[n] = src[n] ? dsp_vld_i[n] : apply_wr && sys.wdata[n];
      chg[n] = ctrl_wr && (sys.wdata[n] != src[n] || sys.wdata[8+n] != sync[n]);
      commit[n] = (req[n] && (!sync[n] || pwm_s_i[n])) || (armed[n] && pwm_s_i[n] && !chg[n]);
    end
  end
  always_comb begin
    rd = '0;
    for (int n = 0; n < CH; n++) rd = sys.addr == 8'(4*n) ? 32'(shadow[n]) : rd;
    rd = sys.addr == 8'h20 ? 32'(src) | (32'(sync) << 8) : rd;
    rd = sys.addr == 8'h28 ? 32'(armed) : rd;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sys.ack <= 1'b0;
      sys.rdata <= '0;
      src <= '0;
      sync <= '0;
      armed <= '0;
      cfg_o <= '0;
      cfg_upd_o <= '0;
      for (int n = 0; n < CH; n++) begin
        shadow[n] <= '0;
        stage[n] <= '0;
      end
    end else begin
      sys.ack <= sys.wen || sys.ren;
      sys.rdata <= sys.ren ? rd : '0;
      cfg_upd_o <= commit;
      if (ctrl_wr) begin
        src <= sys.wdata[CH-1:0];
        sync <= sys.wdata[8 +: CH];
      end
      for (int n = 0; n < CH; n++) begin
        if (sys.wen && sys.addr == 8'(4*n)) shadow[n] <= sys.wdata[CCW-1:0];
        if (dsp_vld_i[n]) stage[n] <= dsp_dat_i[n*CCW +: CCW];
        // A DSP word arriving on the commit edge is the newest staged content, so forward it.
        if (commit[n]) cfg_o[n*CCW +: CCW] <= src[n] ? (dsp_vld_i[n] ? dsp_dat_i[n*CCW +: CCW] : stage[n]) : shadow[n];
        armed[n] <= !chg[n] && !commit[n] && (armed[n] || (req[n] && sync[n]));
      end
    end
  end
endmodule

// File: tb/tb_pwm_cfg_sched.sv
// tb_pwm_cfg_sched: directed scenarios plus random traffic checked against a rule-level model.
module tb_pwm_cfg_sched;
  localparam int CH = 4;
  localparam int CCW = 24;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pwm_cfg_sched_if sys();
  logic [CH*CCW-1:0] dsp_dat, cfg;
  logic [CH-1:0] dsp_vld, pws, upd, pend;
  pwm_cfg_sched #(.CH(CH), .CCW(CCW)) dut (
    .clk(clk), .rst(rst), .sys(sys), .dsp_dat_i(dsp_dat), .dsp_vld_i(dsp_vld),
    .pwm_s_i(pws), .cfg_o(cfg), .cfg_upd_o(upd), .pend_o(pend)
  );
  int n_chk = 0;
  int n_fail = 0;
  logic [CCW-1:0] m_sh [CH];
  logic [CCW-1:0] m_st [CH];
  logic [CCW-1:0] m_cfg [CH];
  logic [CH-1:0] m_src, m_sync, m_pend, m_upd;
  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic m_reset();
    for (int n = 0; n < CH; n++) begin
      m_sh[n] = '0;
      m_st[n] = '0;
      m_cfg[n] = '0;
    end
    m_src = '0;
    m_sync = '0;
    m_pend = '0;
    m_upd = '0;
  endtask
  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (a < 8'(4*CH) && a[1:0] == 2'b00) return 32'(m_sh[int'(a) / 4]);
    if (a == 8'h20) return {16'h0, 8'(m_sync), 8'(m_src)};
    if (a == 8'h28) return 32'(m_pend);
    return 32'h0;
  endfunction
  function automatic logic [CH*CCW-1:0] m_cfg_vec();
    logic [CH*CCW-1:0] r;
    for (int n = 0; n < CH; n++) r[n*CCW +: CCW] = m_cfg[n];
    return r;
  endfunction
  // Applies the current inputs to the model, clocks once, then compares every output.
  task automatic step();
    logic [31:0] er;
    logic was_rd, was_acc, ctrl_w;
    er = m_read(sys.addr);
    was_rd = sys.ren;
    was_acc = sys.wen || sys.ren;
    ctrl_w = sys.wen && sys.addr == 8'h20;
    for (int n = 0; n < CH; n++) begin
      logic [CCW-1:0] dn, val;
      logic asked, aborted, fire;
      dn = dsp_dat[n*CCW +: CCW];
      asked = m_src[n] ? dsp_vld[n] : (sys.wen && sys.addr == 8'h24 && sys.wdata[n]);
      aborted = ctrl_w && ({sys.wdata[8+n], sys.wdata[n]} != {m_sync[n], m_src[n]});
      val = m_src[n] ? (dsp_vld[n] ? dn : m_st[n]) : m_sh[n];
      fire = (m_pend[n] && pws[n] && !aborted) || (asked && (!m_sync[n] || pws[n]));
      if (fire) m_cfg[n] = val;
      m_upd[n] = fire;
      m_pend[n] = !aborted && !fire && (m_pend[n] || (asked && m_sync[n]));
      if (dsp_vld[n]) m_st[n] = dn;
      if (sys.wen && sys.addr == 8'(4*n)) m_sh[n] = sys.wdata[CCW-1:0];
    end
    if (ctrl_w) begin
      m_src = sys.wdata[CH-1:0];
      m_sync = sys.wdata[8 +: CH];
    end
    @(posedge clk);
    #1;
    chk("cfg", 128'(cfg), 128'(m_cfg_vec()));
    chk("upd", 128'(upd), 128'(m_upd));
    chk("pend", 128'(pend), 128'(m_pend));
    chk("ack", 128'(sys.ack), 128'(was_acc));
    if (was_rd) chk("rdata", 128'(sys.rdata), 128'(er));
    sys.wen = 1'b0;
    sys.ren = 1'b0;
    dsp_vld = '0;
    pws = '0;
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    sys.addr = a;
    sys.wdata = d;
    sys.wen = 1'b1;
    step();
  endtask
  task automatic rd(input logic [7:0] a);
    sys.addr = a;
    sys.ren = 1'b1;
    step();
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask
  logic [CCW-1:0] w3;
  initial begin
    sys.addr = '0;
    sys.wdata = '0;
    sys.wen = 1'b0;
    sys.ren = 1'b0;
    dsp_dat = '0;
    dsp_vld = '0;
    pws = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_cfg", 128'(cfg), 128'(0));
    chk("rst_pend", 128'(pend), 128'(0));
    chk("rst_ack", 128'(sys.ack), 128'(0));
    chk("rst_rdata", 128'(sys.rdata), 128'(0));
    rd(8'h00);
    rd(8'h20);
    rd(8'h28);
    // immediate commit from the bus shadow
    wr(8'h00, 32'h0080_0001);
    wr(8'h24, 32'h1);
    chk("imm_cfg", 128'(cfg[CCW-1:0]), 128'(24'h800001));
    chk("imm_upd", 128'(upd[0]), 128'(1));
    chk("imm_pend", 128'(pend), 128'(0));
    // sync commit waits for pwm_s
    wr(8'h20, 32'h100);
    wr(8'h00, 32'h0040_0000);
    wr(8'h24, 32'h1);
    chk("sync_pend", 128'(pend[0]), 128'(1));
    idle(49);
    chk("sync_hold", 128'(cfg[CCW-1:0]), 128'(24'h800001));
    pws[0] = 1'b1;
    step();
    chk("sync_cfg", 128'(cfg[CCW-1:0]), 128'(24'h400000));
    chk("sync_clr", 128'(pend[0]), 128'(0));
    wr(8'h24, 32'h1);
    idle(5);
    wr(8'h00, 32'h0041_0000);
    idle(5);
    pws[0] = 1'b1;
    step();
    chk("late_cfg", 128'(cfg[CCW-1:0]), 128'(24'h410000));
    // DSP source, sync: only the last staged word is committed
    wr(8'h20, 32'h202);
    for (int i = 0; i < 3; i++) begin
      w3 = CCW'($urandom);
      dsp_dat[CCW +: CCW] = w3;
      dsp_vld[1] = 1'b1;
      step();
      chk("dsp_noupd", 128'(upd[1]), 128'(0));
      idle(3);
    end
    pws[1] = 1'b1;
    step();
    chk("dsp_upd", 128'(upd[1]), 128'(1));
    chk("dsp_cfg", 128'(cfg[CCW +: CCW]), 128'(w3));
    idle(2);
    // request coincident with pwm_s commits on that edge
    wr(8'h20, 32'h100);
    wr(8'h00, 32'h0012_3456);
    sys.addr = 8'h24;
    sys.wdata = 32'h1;
    sys.wen = 1'b1;
    pws[0] = 1'b1;
    step();
    chk("coin_upd", 128'(upd[0]), 128'(1));
    chk("coin_cfg", 128'(cfg[CCW-1:0]), 128'(24'h123456));
    // flipping SRC while armed aborts without a commit
    wr(8'h24, 32'h1);
    wr(8'h20, 32'h101);
    chk("abort_pend", 128'(pend[0]), 128'(0));
    chk("abort_upd", 128'(upd[0]), 128'(0));
    pws[0] = 1'b1;
    step();
    chk("abort_noupd", 128'(upd[0]), 128'(0));
    // async reset while armed
    wr(8'h20, 32'h100);
    wr(8'h24, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_cfg", 128'(cfg), 128'(0));
    chk("arst_pend", 128'(pend), 128'(0));
    m_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    pws[0] = 1'b1;
    step();
    chk("arst_noupd", 128'(upd), 128'(0));
    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 2) begin
        sys.addr = 8'(4 * $urandom_range(0, CH - 1));
        sys.wdata = $urandom;
        sys.wen = 1'b1;
      end else if (op == 3) begin
        sys.addr = 8'h20;
        sys.wdata = $urandom;
        sys.wen = 1'b1;
      end else if (op == 4) begin
        sys.addr = 8'h24;
        sys.wdata = $urandom;
        sys.wen = 1'b1;
      end else if (op == 5) begin
        sys.addr = 8'(4 * $urandom_range(0, 13));
        sys.ren = 1'b1;
        sys.wen = $urandom_range(0, 3) == 0;
        sys.wdata = $urandom;
      end
      dsp_dat = {$urandom, $urandom, $urandom};
      for (int n = 0; n < CH; n++) begin
        dsp_vld[n] = $urandom_range(0, 3) == 0;
        pws[n] = $urandom_range(0, 7) == 0;
      end
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
